// File: rtl/cpm_exp.sv
// rtl/cpm_exp.sv - expands clipped OW-bit samples to DW bits through a 2-entry FIFO, counting boundary codes.
// Optional macro CPM_EXP_RND_EN: mid-rise reconstruction offset added after the scale-restore shift.
module cpm_exp #(
    parameter int DW = 12,
    parameter int OW = 8,
    parameter int SW = 3,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [SW-1:0] CFG_SHF,
    input  logic          CFG_CLR,
    input  logic          IN_VLD,
    output logic          IN_RDY,
    input  logic [OW-1:0] IN_DAT,
    output logic          OUT_VLD,
    input  logic          OUT_RDY,
    output logic [DW-1:0] OUT_DAT,
    output logic [CW-1:0] EDGE_CNT,
    output logic          EDGE_FLG
);

    localparam logic [SW-1:0] SHF_MAX  = SW'(DW - OW);
    localparam logic [OW-1:0] CODE_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic [OW-1:0] CODE_MAX = ~CODE_MIN;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [DW-1:0] ONE      = DW'(1);

    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          out_vld_q, out_vld_d;
    logic [CW-1:0] ecnt_q, ecnt_d;
    logic          eflg_q, eflg_d;

    logic          acc, pop, bnd;
    logic [SW-1:0] shf_eff;
    logic [DW-1:0] sext, expd;

    // Ready is a pure function of occupancy (plus reset), never of OUT_RDY.
    assign IN_RDY   = ~RST & (cnt_q != 2'd2);
    assign OUT_VLD  = out_vld_q;
    assign OUT_DAT  = head_q;
    assign EDGE_CNT = ecnt_q;
    assign EDGE_FLG = eflg_q;

    assign acc = IN_VLD & IN_RDY;
    assign pop = out_vld_q & OUT_RDY;
    assign bnd = (IN_DAT == CODE_MIN) || (IN_DAT == CODE_MAX);

    always_comb begin
        shf_eff = (CFG_SHF > SHF_MAX) ? SHF_MAX : CFG_SHF;
        sext    = {{(DW-OW){IN_DAT[OW-1]}}, IN_DAT};
`ifdef CPM_EXP_RND_EN
        // (1<<s)>>1 is 2^(s-1) for s>0 and zero for s=0.
        expd    = (sext << shf_eff) + ((ONE << shf_eff) >> 1);
`else
        expd    = sext << shf_eff;
`endif
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({acc, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = expd;
                else               tail_d = expd;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) head_d = tail_q;
                cnt_d = cnt_q - 2'd1;
            end
            // Simultaneous accept and pop only occurs at occupancy 1.
            2'b11: head_d = expd;
            default: ;
        endcase
        out_vld_d = (cnt_d != 2'd0);

        ecnt_d = ecnt_q;
        if (CFG_CLR)
            ecnt_d = '0;
        else if (acc && bnd && (ecnt_q != CNT_MAX))
            ecnt_d = ecnt_q + CW'(1);
        eflg_d = acc ? bnd : eflg_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q     <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            out_vld_q <= 1'b0;
            ecnt_q    <= '0;
            eflg_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            out_vld_q <= out_vld_d;
            ecnt_q    <= ecnt_d;
            eflg_q    <= eflg_d;
        end
    end

endmodule
